// File: rtl/sysarr_out_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// sysarr_out_drain_ctrl_if
// Bundle of the drain controller's handshake and bus signals.
//   master : array/FIFO/writeback side (drives start, element stream,
//            fifo_out and wb_ready)
//   slave  : the drain controller
// Signals:
//   start            master->slave  begin draining one N x N matrix
//   in_valid/value   master->slave  result element stream
//   in_ready         slave->master  element accepted this cycle
//   fifo_shift       slave->master  shift strobe to the output FIFO
//   fifo_shift_value slave->master  value shifted into the FIFO
//   fifo_out         master->slave  packed FIFO contents
//   wb_valid/data/row slave->master packed row offered to writeback
//   wb_ready         master->slave  writeback accepts the row
//   busy, done, err_start slave->master  status
// ---------------------------------------------------------------------------
interface sysarr_out_drain_ctrl_if #(
    parameter int DW = 16,
    parameter int N  = 4
);
    localparam int RW = $clog2(N);

    logic            start;
    logic            in_valid;
    logic [DW-1:0]   in_value;
    logic            in_ready;
    logic            fifo_shift;
    logic [DW-1:0]   fifo_shift_value;
    logic [DW*N-1:0] fifo_out;
    logic            wb_valid;
    logic [DW*N-1:0] wb_data;
    logic [RW-1:0]   wb_row;
    logic            wb_ready;
    logic            busy;
    logic            done;
    logic            err_start;

    modport master (
        output start, in_valid, in_value, fifo_out, wb_ready,
        input  in_ready, fifo_shift, fifo_shift_value, wb_valid, wb_data,
               wb_row, busy, done, err_start
    );

    modport slave (
        input  start, in_valid, in_value, fifo_out, wb_ready,
        output in_ready, fifo_shift, fifo_shift_value, wb_valid, wb_data,
               wb_row, busy, done, err_start
    );
endinterface

// File: rtl/sysarr_out_drain_ctrl.sv
// ---------------------------------------------------------------------------
// sysarr_out_drain_ctrl
// Sequences result drain from the systolic array into the output shift FIFO
// and hands each completed row (N elements) to writeback. The array is
// stalled (in_ready low) while a row is offered. After N rows a one-cycle
// done pulse is issued.
// Ports:
//   clk          clock, all logic on posedge
//   nRST         synchronous active-low reset
//   bus          sysarr_out_drain_ctrl_if.slave (element stream, FIFO
//                strobe, writeback port, status)
//   stall_cycles [31:0] OUT cycles with wb_ready low, saturating
//                (only when SYSARR_DRAIN_PERF_EN is defined)
// Optional feature macro: SYSARR_DRAIN_PERF_EN
// ---------------------------------------------------------------------------
module sysarr_out_drain_ctrl #(
    parameter int DW = 16,
    parameter int N  = 4
) (
    input  logic                    clk,
    input  logic                    nRST,
    sysarr_out_drain_ctrl_if.slave  bus
`ifdef SYSARR_DRAIN_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, OUT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic          r_busy;
    logic          r_in_ready;
    logic          r_wb_valid;
    logic          r_done;
    logic          r_err_start;

    logic          w_last_col;
    logic          w_last_row;

    assign w_last_col = (r_col == CW'(N - 1));
    assign w_last_row = (r_row == CW'(N - 1));

    // r_in_ready is high exactly in FILL, so it qualifies the shift strobe.
    assign bus.fifo_shift       = r_in_ready & bus.in_valid;
    assign bus.fifo_shift_value = bus.in_value;
    assign bus.in_ready         = r_in_ready;
    assign bus.wb_valid         = r_wb_valid;
    assign bus.wb_data          = bus.fifo_out;
    assign bus.wb_row           = r_row;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.err_start        = r_err_start;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err_start <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start && (r_state != IDLE)) begin
                r_err_start <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= FILL;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        if (w_last_col) begin
                            r_state    <= OUT;
                            r_col      <= '0;
                            r_in_ready <= 1'b0;
                            r_wb_valid <= 1'b1;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                        if (w_last_row) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= FILL;
                            r_row      <= r_row + CW'(1);
                            r_col      <= '0;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYSARR_DRAIN_PERF_EN
    logic [31:0] r_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_stall <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_stall <= '0;
        end else if ((r_state == OUT) && !bus.wb_ready) begin
            r_stall <= sat_inc(r_stall);
        end
    end

    assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_sysarr_out_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sysarr_out_drain_ctrl
// Self-checking bench for sysarr_out_drain_ctrl (N=4, DW=16). A small
// row-level reference model (queue of accepted elements, row counter,
// pending-writeback flag) predicts every output each cycle. A table of
// drain scenarios checks first-row packing, drain latency and sticky
// error; hand sequences cover reset, idle backpressure and reset mid-row;
// chained randomized matrices start in the done cycle of the previous one.
// ---------------------------------------------------------------------------
module tb_sysarr_out_drain_ctrl;
    localparam int DW = 16;
    localparam int N  = 4;
    typedef logic [DW*N-1:0] row_t;

    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    sysarr_out_drain_ctrl_if #(.DW(DW), .N(N)) bus ();
`ifdef SYSARR_DRAIN_PERF_EN
    logic [31:0] stall_cycles;
`endif

    sysarr_out_drain_ctrl #(.DW(DW), .N(N)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
`ifdef SYSARR_DRAIN_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Output shift FIFO: newest element enters at the bottom.
    row_t fifo_q = '0;
    always_ff @(posedge clk) begin
        if (bus.fifo_shift) fifo_q <= {fifo_q[DW*(N-1)-1:0], bus.fifo_shift_value};
    end
    assign bus.fifo_out = fifo_q;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit            m_busy, m_out, m_done, m_err, m_fin, m_acc_evt, m_after_rst;
    int            m_rows;
    logic [DW-1:0] m_rowq[$];
    logic [31:0]   m_stall;

    int   step_idx = 0;
    int   start_step, done_step;
    row_t cap_row0;
    bit   cap_valid;

    typedef struct {
        logic [DW-1:0] base;
        bit            gap;
        int            stall;
        bit            mid_start;
        row_t          exp_row0;
        int            exp_cyc;
        bit            exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_idx);
        end
    endtask

    function automatic row_t pack_row();
        row_t r = '0;
        foreach (m_rowq[i]) r[DW*(N-1-i) +: DW] = m_rowq[i];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_out = 0; m_done = 0; m_err = 0; m_fin = 0;
        m_acc_evt = 0; m_after_rst = 1; m_rows = 0; m_stall = '0;
        m_rowq.delete();
    endtask

    // One clock: drive inputs at negedge, check outputs, advance the model
    // to what must hold after the following posedge.
    task automatic step(input logic st, input logic iv, input logic [DW-1:0] val,
                        input logic wr, input logic rstn);
        bit exp_sh, done_nx, was_busy, was_out;
        @(negedge clk);
        bus.start = st; bus.in_valid = iv; bus.in_value = val;
        bus.wb_ready = wr; nRST = rstn;
        #1;
        step_idx++;
        exp_sh = m_busy && !m_out && iv;
        chk("busy",       128'(bus.busy),       128'(m_busy));
        chk("in_ready",   128'(bus.in_ready),   128'(m_busy && !m_out));
        chk("wb_valid",   128'(bus.wb_valid),   128'(m_out));
        chk("fifo_shift", 128'(bus.fifo_shift), 128'(exp_sh));
        chk("done",       128'(bus.done),       128'(m_done));
        chk("err_start",  128'(bus.err_start),  128'(m_err));
        if (exp_sh) chk("shift_value", 128'(bus.fifo_shift_value), 128'(val));
        if (m_out) begin
            chk("wb_data", 128'(bus.wb_data), 128'(pack_row()));
            chk("wb_row",  128'(bus.wb_row),  128'(m_rows));
        end
        if (m_after_rst) chk("wb_row_reset", 128'(bus.wb_row), 128'(0));
`ifdef SYSARR_DRAIN_PERF_EN
        chk("stall_cycles", 128'(stall_cycles), 128'(m_stall));
`endif
        if (bus.done === 1'b1) done_step = step_idx;
        if (bus.wb_valid === 1'b1 && !cap_valid) begin
            cap_row0  = bus.wb_data;
            cap_valid = 1;
        end

        m_acc_evt = 0;
        done_nx   = 0;
        was_busy  = m_busy;
        was_out   = m_out;
        if (!rstn) begin
            model_reset();
        end else if (!was_busy) begin
            if (st) begin
                m_busy = 1; m_out = 0; m_rows = 0; m_stall = '0;
                m_after_rst = 0; m_rowq.delete();
            end
        end else begin
            if (st) m_err = 1;
            if (!was_out) begin
                if (iv) begin
                    m_rowq.push_back(val);
                    m_acc_evt = 1;
                    if (m_rowq.size() == N) m_out = 1;
                end
            end else if (wr) begin
                m_rowq.delete();
                if (m_rows == N - 1) begin
                    m_busy = 0; m_out = 0; done_nx = 1; m_fin = 1;
                end else begin
                    m_rows++;
                    m_out = 0;
                end
            end else if (m_stall != 32'hFFFF_FFFF) begin
                m_stall = m_stall + 32'd1;
            end
        end
        m_done = done_nx;
    endtask

    // Start a matrix and stream it until the final writeback handshake.
    task automatic run_matrix(input logic [DW-1:0] base, input bit gap, input int stall_len,
                              input bit mid_start, input bit rnd);
        logic [DW-1:0] v;
        logic iv, wr, st;
        int   cyc  = 0;
        int   used = 0;
        bit   hold = 0;
        v = rnd ? DW'($urandom) : base;
        cap_valid = 0;
        m_fin     = 0;
        done_step = -1;
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        start_step = step_idx;
        while (!m_fin && cyc < 400) begin
            iv = rnd ? 1'($urandom_range(0, 1)) : !(gap && hold);
            wr = 1'b1;
            if (rnd) wr = ($urandom_range(0, 2) != 0);
            else if (m_out && m_rows == 1 && used < stall_len) begin
                wr = 1'b0;
                used++;
            end
            st = mid_start && (cyc == 2);
            step(st, iv, v, wr, 1'b1);
            cyc++;
            hold = m_acc_evt;
            if (m_acc_evt) v = rnd ? DW'($urandom) : v + DW'(1);
        end
        if (!m_fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: no final handshake after %0d cycles, required one", cyc);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0001, 1'b0, 0, 1'b0, 64'h0001_0002_0003_0004, 20, 1'b0};
        vecs[1] = '{16'h0001, 1'b0, 5, 1'b0, 64'h0001_0002_0003_0004, 25, 1'b0};
        vecs[2] = '{16'h0100, 1'b1, 0, 1'b0, 64'h0100_0101_0102_0103, 32, 1'b0};
        vecs[3] = '{16'hFFFD, 1'b1, 3, 1'b0, 64'hFFFD_FFFE_FFFF_0000, 35, 1'b0};
        vecs[4] = '{16'h00A0, 1'b0, 0, 1'b1, 64'h00A0_00A1_00A2_00A3, 20, 1'b1};

        bus.start = 0; bus.in_valid = 0; bus.in_value = '0; bus.wb_ready = 0;
        nRST = 0;
        @(posedge clk);
        model_reset();

        // Reset held two cycles, then idle with in_valid high and no start.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);

        // Scenario table
        for (int i = 0; i < 5; i++) begin
            run_matrix(vecs[i].base, vecs[i].gap, vecs[i].stall, vecs[i].mid_start, 1'b0);
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
            chk("row0_data",    128'(cap_row0), 128'(vecs[i].exp_row0));
            chk("drain_cycles", 128'(done_step - start_step - 1), 128'(vecs[i].exp_cyc));
            chk("err_sticky",   128'(bus.err_start), 128'(vecs[i].exp_err));
`ifdef SYSARR_DRAIN_PERF_EN
            chk("stall_total",  128'(stall_cycles), 128'(vecs[i].stall));
`endif
        end

        // Reset after two of four elements: aborts the matrix, clears err_start.
        step(1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0011, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0012, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0013, 1'b1, 1'b1);
        chk("err_after_reset", 128'(bus.err_start), 128'(0));
        step(1'b0, 1'b1, 16'h0014, 1'b1, 1'b1);
        run_matrix(16'h0050, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("rst_row0_data",    128'(cap_row0), 128'(64'h0050_0051_0052_0053));
        chk("rst_drain_cycles", 128'(done_step - start_step - 1), 128'(20));

        // Randomized matrices, each started in the done cycle of the previous.
        for (int i = 0; i < 6; i++) run_matrix('0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h7777, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
